// File: rtl/ps2_scan_decoder_pkg.sv
// Shared PS/2 scan-code constants, key bitmap indices and key lookup.
// Also imported by control_host for the arrow ASCII codes and key indices.
package ps2_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] ASCII_LEFT  = 8'h11;
    localparam logic [7:0] ASCII_RIGHT = 8'h12;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_LEFT  = 4;
    localparam int KEY_RIGHT = 5;
    localparam int KEY_NUM   = 6;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] code;
    } key_map_t;

    // Arrow codes only match behind an E0 prefix, letters only without it.
    function automatic key_map_t key_map(input logic [7:0] sc,
                                         input logic       ext);
        key_map_t m;
        m = '0;
        case ({ext, sc})
            {1'b0, SC_W}:     m = '{1'b1, 3'(KEY_W), 8'h77};
            {1'b0, SC_A}:     m = '{1'b1, 3'(KEY_A), 8'h61};
            {1'b0, SC_S}:     m = '{1'b1, 3'(KEY_S), 8'h73};
            {1'b0, SC_D}:     m = '{1'b1, 3'(KEY_D), 8'h64};
            {1'b1, SC_LEFT}:  m = '{1'b1, 3'(KEY_LEFT), ASCII_LEFT};
            {1'b1, SC_RIGHT}: m = '{1'b1, 3'(KEY_RIGHT), ASCII_RIGHT};
            default:          m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_clk_filter.sv
// Two-flop synchronisers for PS2C/PS2D plus a run-length glitch filter
// on the clock; emits a one-cycle strobe on each filtered falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            level  <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
            data   <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            fall   <= 1'b0;
            if (c_sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt   <= '0;
                level <= c_sync[1];
                if (level) begin
                    fall <= 1'b1;
                    data <= d_sync[1];
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: frame FSM with parity/stop/timeout checking and
// a make/break decoder for WASD and the left/right arrow keys.
module ps2_scan_decoder
    import ps2_scan_decoder_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] ascii,
    output logic       key_valid,
    output logic [5:0] key_state,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic         fall;
    logic         data;
    frame_state_t state;
    frame_state_t state_d;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         par;
    logic [TW-1:0] to_cnt;
    logic         timeout;
    logic         deliver;
    logic         err;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         ext;
    logic         brk;
    key_map_t     km;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk (clk),
        .rst (rst),
        .ps2c(PS2C),
        .ps2d(PS2D),
        .fall(fall),
        .data(data)
    );

    assign timeout = (state != ST_IDLE) && !fall &&
                     (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state;
        deliver = 1'b0;
        err     = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            err     = 1'b1;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!data) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data && (^{shreg, par})) deliver = 1'b1;
                    else                         err     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            rx_valid  <= deliver;
            frame_err <= err;
            if (deliver) rx_byte <= shreg;
            if (state == ST_IDLE || fall) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;
            if (timeout) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (fall) begin
                unique case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                    ST_DATA: begin
                        shreg   <= {data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: par <= data;
                    ST_STOP:   ;
                endcase
            end
        end
    end

    assign km = key_map(rx_byte, ext);

    // Prefix bytes only arm flags; any other delivered byte consumes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            ascii     <= 8'h00;
            key_state <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (km.hit) begin
                        if (brk) begin
                            key_state[km.idx] <= 1'b0;
                            if (ascii == km.code) ascii <= 8'h00;
                        end else if (!key_state[km.idx]) begin
                            key_state[km.idx] <= 1'b1;
                            ascii             <= km.code;
                            key_valid         <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed and randomized PS/2 frames checked against a key-table model.
module tb_ps2_scan_decoder;

    localparam int TO = 50000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] ascii;
    logic       key_valid;
    logic [5:0] key_state;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;

    logic [7:0] m_ascii  = 8'h00;
    logic [5:0] m_keys   = 6'b0;
    bit         m_ext    = 1'b0;
    bit         m_brk    = 1'b0;
    int         m_pulses = 0;
    int         m_errs   = 0;

    logic [7:0] k_code [6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h6B, 8'h74};
    bit         k_ext  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] k_char [6] = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h11, 8'h12};
    logic [7:0] pool   [10] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h6B,
                                8'h74, 8'hE0, 8'hF0, 8'h12, 8'h5A};

    ps2_scan_decoder #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PS2C     (ps2c),
        .PS2D     (ps2d),
        .ascii    (ascii),
        .key_valid(key_valid),
        .key_state(key_state),
        .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ascii"}, 32'(ascii), 32'(m_ascii));
        check({tag, "_keys"}, 32'(key_state), 32'(m_keys));
        check({tag, "_pulses"}, kv_cnt, m_pulses);
        check({tag, "_errs"}, fe_cnt, m_errs);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (k_code[i] == b && k_ext[i] == m_ext) begin
                    if (m_brk) begin
                        m_keys[i] = 1'b0;
                        if (m_ascii == k_char[i]) m_ascii = 8'h00;
                    end else if (!m_keys[i]) begin
                        m_keys[i] = 1'b1;
                        m_ascii   = k_char[i];
                        m_pulses++;
                    end
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v, input int hp, input bit g);
        ps2d = v;
        if (g) begin
            tick(hp / 2); ps2c = 1'b0; tick(2); ps2c = 1'b1;
            tick(hp - hp / 2 - 2);
        end else tick(hp);
        ps2c = 1'b0;
        if (g) begin
            tick(hp / 2); ps2c = 1'b1; tick(2); ps2c = 1'b0;
            tick(hp - hp / 2 - 2);
        end else tick(hp);
        ps2c = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bp, input bit bs,
                         input int hp, input bit g);
        ps2_bit(1'b0, hp, g);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], hp, g);
        ps2_bit((~^b) ^ bp, hp, g);
        ps2_bit(~bs, hp, g);
        ps2d = 1'b1;
        tick(hp);
        if (bp || bs) m_errs++;
        else          model_byte(b);
    endtask

    initial begin
        logic [7:0] b;
        bit bp, bs;
        tick(3);
        check("rst_ascii", 32'(ascii), 0);
        check("rst_keys", 32'(key_state), 0);
        check("rst_kv", 32'(key_valid), 0);
        check("rst_fe", 32'(frame_err), 0);
        rst = 1'b1;
        tick(10);

        frame(8'h1D, 0, 0, 500, 0);
        check("w_ascii", 32'(ascii), 32'h77);
        check("w_keys", 32'(key_state), 32'b000001);
        check_all("w");

        frame(8'h1D, 0, 0, 16, 0);
        frame(8'h1D, 0, 0, 16, 0);
        check_all("repeat");
        frame(8'hF0, 0, 0, 16, 0);
        frame(8'h1D, 0, 0, 16, 0);
        check("wbrk_ascii", 32'(ascii), 0);
        check("wbrk_pulses", kv_cnt, 1);
        check_all("wbrk");

        frame(8'hE0, 0, 0, 16, 0);
        frame(8'h6B, 0, 0, 16, 0);
        check("left_ascii", 32'(ascii), 32'h11);
        frame(8'h1C, 0, 0, 16, 0);
        check("a_ascii", 32'(ascii), 32'h61);
        check("a_keys", 32'(key_state), 32'b010010);
        frame(8'hF0, 0, 0, 16, 0);
        frame(8'h1C, 0, 0, 16, 0);
        check("abrk_ascii", 32'(ascii), 0);
        check("abrk_keys", 32'(key_state), 32'b010000);
        frame(8'hE0, 0, 0, 16, 0);
        frame(8'hF0, 0, 0, 16, 0);
        frame(8'h6B, 0, 0, 16, 0);
        check_all("leftbrk");

        frame(8'h1D, 1, 0, 16, 0);
        check("par_keys", 32'(key_state), 0);
        check_all("parity");

        ps2_bit(1'b0, 16, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(8'h1D >> i), 16, 0);
        ps2d = 1'b1;
        tick(TO + 100);
        m_errs++;
        check_all("timeout");
        frame(8'h23, 0, 0, 16, 0);
        check("d_ascii", 32'(ascii), 32'h64);
        check_all("after_to");

        frame(8'h1B, 0, 0, 32, 1);
        check("glitch_ascii", 32'(ascii), 32'h73);
        check_all("glitch");

        ps2_bit(1'b0, 16, 0);
        ps2_bit(1'b1, 16, 0);
        ps2d = 1'b0;
        ps2c = 1'b0;
        tick(4);
        rst = 1'b0;
        #1;
        check("mrst_ascii", 32'(ascii), 0);
        check("mrst_keys", 32'(key_state), 0);
        check("mrst_kv", 32'(key_valid), 0);
        check("mrst_fe", 32'(frame_err), 0);
        m_ascii = 8'h00;
        m_keys  = 6'b0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        tick(2);
        ps2c = 1'b1;
        ps2d = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(20);
        frame(8'h1D, 0, 0, 16, 0);
        check_all("post_rst");

        for (int r = 0; r < 20; r++) begin
            b  = pool[$urandom_range(0, 9)];
            bp = ($urandom_range(0, 7) == 0);
            bs = !bp && ($urandom_range(0, 9) == 0);
            frame(b, bp, bs, $urandom_range(12, 20), 0);
            check_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
